// File: rtl/processed_frame_reader_if.sv
// Processing-memory read port plus the outgoing pixel stream of processed_frame_reader.
// master = the reader; slave = memory/downstream side.
interface processed_frame_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
);
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_eol;
  logic                  m_last;

  modport master (
    output r_en, r_addr, m_data, m_valid, m_eol, m_last,
    input  r_data, m_ready
  );

  modport slave (
    input  r_en, r_addr, m_data, m_valid, m_eol, m_last,
    output r_data, m_ready
  );
endinterface

// File: rtl/processed_frame_reader.sv
// Streams a finished frame out of the processing memory on start's rising edge; 2 cycles from r_en to m_valid.
// Reads are throttled so a 2-entry FIFO absorbs m_ready backpressure. Optional BORDER_BLANK_EN zeroes border pixels.
module processed_frame_reader #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_LENGTH = 120000,
  parameter int IMG_WIDTH   = 300
) (
  input  logic                     clk_p,
  input  logic                     rst_n,
  input  logic                     start,
  processed_frame_reader_if.master bus,
  output logic                     busy,
  output logic                     done
);

  localparam int COL_WIDTH = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_LENGTH - 1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);
`ifdef BORDER_BLANK_EN
  localparam logic [ADDR_WIDTH-1:0] ROW1_IDX     = ADDR_WIDTH'(IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_IDX = ADDR_WIDTH'(DATA_LENGTH - IMG_WIDTH);
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic                  eol;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  logic                  start_prev_q, start_prev_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_eol_q, tag_eol_d;
  logic                  tag_last_q, tag_last_d;
`ifdef BORDER_BLANK_EN
  logic                  tag_blank_q, tag_blank_d;
`endif
  entry_t                fifo_q [2];
  entry_t                fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic   issue, push, pop;
  entry_t head, wr_entry;

  always_comb begin
    head  = fifo_q[rd_ptr_q];
    pop   = (count_q != 2'd0) && bus.m_ready;
    push  = inflight_q;
    // Reads already in flight count against FIFO space, so a push never meets a full FIFO.
    issue = (state_q == S_FETCH) && ((count_q + {1'b0, inflight_q}) < 2'd2);

    wr_entry.last = tag_last_q;
    wr_entry.eol  = tag_eol_q;
    wr_entry.data = bus.r_data;
`ifdef BORDER_BLANK_EN
    if (tag_blank_q) wr_entry.data = '0;
`endif

    state_d      = state_q;
    start_prev_d = start;
    rd_idx_d     = rd_idx_q;
    col_d        = col_q;
    inflight_d   = issue;
    tag_eol_d    = (col_q == LAST_COL);
    tag_last_d   = (rd_idx_q == LAST_IDX);
`ifdef BORDER_BLANK_EN
    tag_blank_d  = (col_q == '0) || (col_q == LAST_COL) ||
                   (rd_idx_q < ROW1_IDX) || (rd_idx_q >= LAST_ROW_IDX);
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !start_prev_q) begin
          rd_idx_d = '0;
          col_d    = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          // Index parks on the last address instead of running past the frame.
          if (rd_idx_q == LAST_IDX) state_d = S_DRAIN;
          else                      rd_idx_d = rd_idx_q + 1'b1;
          col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop && head.last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = wr_entry;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      rd_idx_q     <= '0;
      col_q        <= '0;
      inflight_q   <= 1'b0;
      tag_eol_q    <= 1'b0;
      tag_last_q   <= 1'b0;
`ifdef BORDER_BLANK_EN
      tag_blank_q  <= 1'b0;
`endif
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      rd_idx_q     <= rd_idx_d;
      col_q        <= col_d;
      inflight_q   <= inflight_d;
      tag_eol_q    <= tag_eol_d;
      tag_last_q   <= tag_last_d;
`ifdef BORDER_BLANK_EN
      tag_blank_q  <= tag_blank_d;
`endif
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.r_en    = issue;
  assign bus.r_addr  = rd_idx_q;
  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = head.data;
  assign bus.m_eol   = head.eol;
  assign bus.m_last  = head.last;
  assign busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule
